// File: rtl/nco_wave_shaper.sv
`default_nettype none
// ============================================================================
// Module : nco_wave_shaper
// Desc   : Converts NCO phase slots into saw/square/triangle/sine samples and
//          sums each voice's oscillators into one voice sample.
// Rev    : 1.0  initial release
// ============================================================================
module nco_wave_shaper #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic                          sCLK_XVXOSC,
  input  logic                          iRST,
  input  logic                          slot_valid,
  input  logic [10:0]                   phase_acc,
  input  logic [V_WIDTH-1:0]            vx,
  input  logic [O_WIDTH-1:0]            ox,
  input  logic                          cfg_wr,
  input  logic [V_WIDTH-1:0]            cfg_vx,
  input  logic [O_WIDTH-1:0]            cfg_ox,
  input  logic [1:0]                    cfg_wave,
  input  logic [10:0]                   cfg_pw,
  output logic signed [15:0]            osc_out,
  output logic                          osc_valid,
  output logic [V_WIDTH-1:0]            osc_vx,
  output logic [O_WIDTH-1:0]            osc_ox,
  output logic signed [16+O_WIDTH-1:0]  voice_out,
  output logic                          voice_valid,
  output logic [V_WIDTH-1:0]            voice_vx
);

  localparam int                   c_ENTRIES     = VOICES * V_OSC;
  localparam logic [12:0]          c_CFG_DEFAULT = {2'd0, 11'd1024};
  localparam logic [1:0]           c_WAVE_SAW    = 2'd0;
  localparam logic [1:0]           c_WAVE_SQUARE = 2'd1;
  localparam logic [1:0]           c_WAVE_TRI    = 2'd2;
  localparam logic [1:0]           c_WAVE_SINE   = 2'd3;
  localparam logic [O_WIDTH-1:0]   c_LAST_OX     = O_WIDTH'(V_OSC - 1);
  localparam logic signed [127:0]  c_SCALE       = 128'sd1000000000000000000;
  localparam logic signed [127:0]  c_PI          = 128'sd3141592653589793238;

  // Elaboration-time Taylor series in 1e18 fixed point; rounds 32767*sin(pi(2k+1)/2048).
  function automatic logic [14:0] f_sine_entry(input int k);
    logic signed [127:0] x, x2, term, sum, r;
    x    = (c_PI * 128'(2 * k + 1)) / 128'sd2048;
    x2   = (x * x) / c_SCALE;
    term = x;
    sum  = x;
    for (int n = 1; n < 16; n++) begin
      term = -((term * x2) / c_SCALE) / 128'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * 128'sd32767 + c_SCALE / 128'sd2) / c_SCALE;
    return 15'(r);
  endfunction

  logic [14:0] w_sine_rom [512];
  for (genvar k = 0; k < 512; k++) begin : g_sine_rom
    localparam logic [14:0] c_ENTRY = f_sine_entry(k);
    assign w_sine_rom[k] = c_ENTRY;
  end

  logic [12:0]                 r_cfg_ram [c_ENTRIES];
  logic                        r1_valid;
  logic [10:0]                 r1_phase;
  logic [V_WIDTH-1:0]          r1_vx;
  logic [O_WIDTH-1:0]          r1_ox;
  logic [12:0]                 r1_cfg;
  logic                        r2_valid;
  logic [V_WIDTH-1:0]          r2_vx;
  logic [O_WIDTH-1:0]          r2_ox;
  logic                        r2_is_sine;
  logic                        r2_neg;
  logic [14:0]                 r2_mag;
  logic [15:0]                 r2_shape;
  logic signed [16+O_WIDTH-1:0] r_acc;
  logic                        r_live;

  logic [9:0]                  w_tri_t;
  logic [8:0]                  w_rom_addr;
  logic [15:0]                 w_shape;
  logic [15:0]                 w_mag16;
  logic [15:0]                 w_sine;
  logic signed [16+O_WIDTH-1:0] w_osc_ext;
  logic signed [16+O_WIDTH-1:0] w_sum;
  logic                        w_first;

  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      for (int e = 0; e < c_ENTRIES; e++) r_cfg_ram[e] <= c_CFG_DEFAULT;
    end else if (cfg_wr) begin
      r_cfg_ram[{cfg_vx, cfg_ox}] <= {cfg_wave, cfg_pw};
    end
  end

  // S1: the RAM read here sees the pre-write contents of a same-cycle config write.
  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      r1_valid <= 1'b0;
      r1_phase <= '0;
      r1_vx    <= '0;
      r1_ox    <= '0;
      r1_cfg   <= c_CFG_DEFAULT;
    end else begin
      r1_valid <= slot_valid;
      r1_phase <= phase_acc;
      r1_vx    <= vx;
      r1_ox    <= ox;
      r1_cfg   <= r_cfg_ram[{vx, ox}];
    end
  end

  always_comb begin
    w_tri_t    = r1_phase[10] ? ~r1_phase[9:0] : r1_phase[9:0];
    w_rom_addr = r1_phase[9] ? ~r1_phase[8:0] : r1_phase[8:0];
    w_shape    = {~r1_phase[10], r1_phase[9:0], 5'b0};
    case (r1_cfg[12:11])
      c_WAVE_SAW:    w_shape = {~r1_phase[10], r1_phase[9:0], 5'b0};
      c_WAVE_SQUARE: w_shape = (r1_phase < r1_cfg[10:0]) ? 16'h7FFF : 16'h8001;
      c_WAVE_TRI:    w_shape = {~w_tri_t[9], w_tri_t[8:0], 6'b0};
      default:       w_shape = 16'h0000;
    endcase
  end

  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      r2_valid   <= 1'b0;
      r2_vx      <= '0;
      r2_ox      <= '0;
      r2_is_sine <= 1'b0;
      r2_neg     <= 1'b0;
      r2_mag     <= '0;
      r2_shape   <= '0;
    end else begin
      r2_valid   <= r1_valid;
      r2_vx      <= r1_vx;
      r2_ox      <= r1_ox;
      r2_is_sine <= (r1_cfg[12:11] == c_WAVE_SINE);
      r2_neg     <= r1_phase[10];
      r2_mag     <= w_sine_rom[w_rom_addr];
      r2_shape   <= w_shape;
    end
  end

  assign w_mag16 = {1'b0, r2_mag};
  assign w_sine  = r2_neg ? (16'd0 - w_mag16) : w_mag16;

  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      osc_out   <= '0;
      osc_valid <= 1'b0;
      osc_vx    <= '0;
      osc_ox    <= '0;
    end else begin
      osc_out   <= r2_is_sine ? w_sine : r2_shape;
      osc_valid <= r2_valid;
      osc_vx    <= r2_vx;
      osc_ox    <= r2_ox;
    end
  end

  // ox==0 restarts the sum; a voice only emits if its ox==0 slot was seen since reset.
  assign w_osc_ext = {{O_WIDTH{osc_out[15]}}, osc_out};
  assign w_first   = (osc_ox == '0);
  assign w_sum     = (w_first ? '0 : r_acc) + w_osc_ext;

  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      r_acc       <= '0;
      r_live      <= 1'b0;
      voice_out   <= '0;
      voice_valid <= 1'b0;
      voice_vx    <= '0;
    end else begin
      voice_valid <= 1'b0;
      if (osc_valid) begin
        r_acc <= w_sum;
        if (w_first) r_live <= 1'b1;
        if (osc_ox == c_LAST_OX) begin
          r_live <= 1'b0;
          if (w_first || r_live) begin
            voice_out   <= w_sum;
            voice_vx    <= osc_vx;
            voice_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_wave_shaper.sv
`default_nettype none
// tb_nco_wave_shaper: directed + scoreboard bench for nco_wave_shaper.
module tb_nco_wave_shaper;
  localparam int VOICES  = 8;
  localparam int V_OSC   = 4;
  localparam int V_WIDTH = 3;
  localparam int O_WIDTH = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     slot_valid = 1'b0;
  logic [10:0]              phase_acc = '0;
  logic [V_WIDTH-1:0]       vx = '0;
  logic [O_WIDTH-1:0]       ox = '0;
  logic                     cfg_wr = 1'b0;
  logic [V_WIDTH-1:0]       cfg_vx = '0;
  logic [O_WIDTH-1:0]       cfg_ox = '0;
  logic [1:0]               cfg_wave = '0;
  logic [10:0]              cfg_pw = '0;
  logic signed [15:0]       osc_out;
  logic                     osc_valid;
  logic [V_WIDTH-1:0]       osc_vx;
  logic [O_WIDTH-1:0]       osc_ox;
  logic signed [17:0]       voice_out;
  logic                     voice_valid;
  logic [V_WIDTH-1:0]       voice_vx;

  nco_wave_shaper #(.VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH)) dut (
    .sCLK_XVXOSC(clk), .iRST(rst), .slot_valid(slot_valid), .phase_acc(phase_acc),
    .vx(vx), .ox(ox), .cfg_wr(cfg_wr), .cfg_vx(cfg_vx), .cfg_ox(cfg_ox),
    .cfg_wave(cfg_wave), .cfg_pw(cfg_pw), .osc_out(osc_out), .osc_valid(osc_valid),
    .osc_vx(osc_vx), .osc_ox(osc_ox), .voice_out(voice_out), .voice_valid(voice_valid),
    .voice_vx(voice_vx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int vx; int ox; int val; } exp_t;
  exp_t q_osc[$];
  exp_t q_voice[$];
  exp_t me;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   wave_m[VOICES*V_OSC];
  int   pw_m[VOICES*V_OSC];
  int   acc_m  = 0;
  bit   live_m = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f_sine_mag(input int k);
    real a;
    a = 32767.0 * $sin(3.14159265358979323846 * real'(2 * k + 1) / 2048.0);
    return $rtoi(a + 0.5);
  endfunction

  function automatic int f_wave(input int w, input int p, input int pw);
    int t, q, i, a, m;
    case (w)
      0: return p * 32 - 32768;
      1: return (p < pw) ? 32767 : -32767;
      2: begin t = (p < 1024) ? p : 2047 - p; return t * 64 - 32768; end
      default: begin
        q = p / 512; i = p % 512;
        a = (q % 2 == 1) ? 511 - i : i;
        m = f_sine_mag(a);
        return (q >= 2) ? -m : m;
      end
    endcase
  endfunction

  // Model the cycle being driven, then advance one clock.
  task automatic tick();
    exp_t e;
    exp_t keep[$];
    int idx, s;
    if (rst) begin
      for (int i = 0; i < VOICES * V_OSC; i++) begin wave_m[i] = 0; pw_m[i] = 1024; end
      acc_m = 0; live_m = 1'b0;
      keep = {};
      foreach (q_osc[i]) if (q_osc[i].due <= cyc) keep.push_back(q_osc[i]);
      q_osc = keep;
      keep = {};
      foreach (q_voice[i]) if (q_voice[i].due <= cyc) keep.push_back(q_voice[i]);
      q_voice = keep;
    end else begin
      if (slot_valid) begin
        idx = int'(vx) * V_OSC + int'(ox);
        s = f_wave(wave_m[idx], int'(phase_acc), pw_m[idx]);
        e.due = cyc + 3; e.vx = int'(vx); e.ox = int'(ox); e.val = s;
        q_osc.push_back(e);
        if (ox == 0) begin acc_m = 0; live_m = 1'b1; end
        if (int'(ox) == V_OSC - 1) begin
          if (live_m) begin
            e.due = cyc + 4; e.ox = 0; e.val = acc_m + s;
            q_voice.push_back(e);
          end
          live_m = 1'b0;
        end
        acc_m = acc_m + s;
      end
      if (cfg_wr) begin
        idx = int'(cfg_vx) * V_OSC + int'(cfg_ox);
        wave_m[idx] = int'(cfg_wave); pw_m[idx] = int'(cfg_pw);
      end
    end
    @(posedge clk); #1;
    slot_valid = 1'b0;
    cfg_wr     = 1'b0;
  endtask

  task automatic set_slot(input int v, input int o, input int p);
    slot_valid = 1'b1; vx = V_WIDTH'(v); ox = O_WIDTH'(o); phase_acc = 11'(p);
  endtask

  task automatic set_cfg(input int v, input int o, input int w, input int pw);
    cfg_wr = 1'b1; cfg_vx = V_WIDTH'(v); cfg_ox = O_WIDTH'(o); cfg_wave = 2'(w); cfg_pw = 11'(pw);
  endtask

  task automatic slot(input int v, input int o, input int p);
    set_slot(v, o, p); tick();
  endtask

  task automatic cfg(input int v, input int o, input int w, input int pw);
    set_cfg(v, o, w, pw); tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Output monitor: every DUT output is matched against the scoreboard front.
  always @(negedge clk) begin
    if (osc_valid) begin
      if (q_osc.size() == 0) chk("osc_valid_unexpected", osc_valid, 0);
      else begin
        me = q_osc.pop_front();
        chk("osc_time", cyc, me.due);
        chk("osc_vx", osc_vx, me.vx);
        chk("osc_ox", osc_ox, me.ox);
        chk("osc_out", osc_out, me.val);
      end
    end else if (q_osc.size() != 0 && q_osc[0].due <= cyc) begin
      chk("osc_valid_missing", osc_valid, 1);
      void'(q_osc.pop_front());
    end
    if (voice_valid) begin
      if (q_voice.size() == 0) chk("voice_valid_unexpected", voice_valid, 0);
      else begin
        me = q_voice.pop_front();
        chk("voice_time", cyc, me.due);
        chk("voice_vx", voice_vx, me.vx);
        chk("voice_out", voice_out, me.val);
      end
    end else if (q_voice.size() != 0 && q_voice[0].due <= cyc) begin
      chk("voice_valid_missing", voice_valid, 1);
      void'(q_voice.pop_front());
    end
  end

  initial begin
    // Reset held two cycles with a valid slot presented.
    rst = 1'b1;
    set_slot(0, 0, 0); tick();
    chk("rst_osc_valid", osc_valid, 0);
    chk("rst_osc_out", osc_out, 0);
    chk("rst_osc_tags", {osc_vx, osc_ox}, 0);
    chk("rst_voice_valid", voice_valid, 0);
    chk("rst_voice_out", voice_out, 0);
    chk("rst_voice_vx", voice_vx, 0);
    set_slot(0, 0, 0); tick();
    rst = 1'b0;
    slot(0, 0, 0);
    idle(4);

    // Sine quadrants.
    cfg(0, 0, 3, 0);
    slot(0, 0, 0); slot(0, 0, 512); slot(0, 0, 1024); slot(0, 0, 1536);

    // Square thresholds and write/read ordering.
    cfg(1, 2, 1, 512);
    slot(1, 2, 511); slot(1, 2, 512);
    set_cfg(1, 2, 1, 0); set_slot(1, 2, 100); tick();
    slot(1, 2, 0);
    cfg(1, 2, 1, 2047);
    slot(1, 2, 2046); slot(1, 2, 2047);

    // Triangle extremes.
    cfg(3, 1, 2, 0);
    slot(3, 1, 0); slot(3, 1, 1023); slot(3, 1, 1024); slot(3, 1, 2047);

    // Voice sum, then the same with a bubble between ox=1 and ox=2.
    for (int o = 0; o < V_OSC; o++) slot(5, o, 2047);
    slot(5, 0, 2047); slot(5, 1, 2047); idle(1); slot(5, 2, 2047); slot(5, 3, 2047);
    idle(5);

    // Interrupted voice 2 followed by a full voice 3.
    slot(2, 0, 300); slot(2, 1, 700);
    slot(3, 0, 100); slot(3, 1, 1500); slot(3, 2, 2000); slot(3, 3, 5);
    idle(5);

    // Random configs per voice, config writes overlapping slot reads of other entries.
    for (int v = 0; v < VOICES; v++) begin
      for (int o = 0; o < V_OSC; o++) cfg(v, o, $urandom_range(0, 3), $urandom_range(0, 2047));
      for (int o = 0; o < V_OSC; o++) begin
        set_slot(v, o, $urandom_range(0, 2047));
        set_cfg((v + 1) % VOICES, o, $urandom_range(0, 3), $urandom_range(0, 2047));
        tick();
      end
    end
    idle(5);

    // Broad sine table sweep on an ox=0 slot.
    cfg(7, 0, 3, 0);
    for (int p = 0; p < 2048; p += 13) slot(7, 0, p);
    slot(7, 0, 2047);
    idle(5);

    // Reset in the middle of a voice, then a clean voice afterwards.
    slot(4, 0, 1000); slot(4, 1, 1000); slot(4, 2, 1000);
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    idle(6);
    for (int o = 0; o < V_OSC; o++) slot(6, o, 1 + 600 * o);
    idle(8);

    chk("osc_queue_drained", q_osc.size(), 0);
    chk("voice_queue_drained", q_voice.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
